// File: rtl/idma_pkg.sv
// rtl/idma_pkg.sv - shared iDMA constants and the transfer-ID increment rule
package idma_pkg;

  localparam int unsigned MaxNumStreams = 16;

  // ID 0 means "nothing done", so the counter wraps from all-ones back to 1.
  function automatic logic [31:0] id_increment(input logic [31:0] id, input int unsigned width);
    logic [31:0] max_id;
    max_id = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (id >= max_id) ? 32'd1 : id + 32'd1;
  endfunction

endpackage

// File: rtl/idma_stream_id_counter.sv
// rtl/idma_stream_id_counter.sv - per-stream next/done transfer IDs and outstanding count
module idma_stream_id_counter
  import idma_pkg::*;
#(
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      inc_next_i,
  input  logic                      inc_done_i,
  output logic [IdCounterWidth-1:0] next_id_o,
  output logic [IdCounterWidth-1:0] done_id_o,
  output logic                      full_o,
  output logic                      busy_o,
  output logic                      done_upd_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  logic [OutW-1:0]           r_outstanding;
  logic [IdCounterWidth-1:0] r_next_id;
  logic [IdCounterWidth-1:0] r_done_id;
  logic [31:0]               w_next_inc;
  logic [31:0]               w_done_inc;
  logic                      w_inc;
  logic                      w_done;

  assign full_o     = (r_outstanding >= OutW'(MaxOutstanding));
  assign busy_o     = (r_outstanding != '0);
  assign w_inc      = inc_next_i & ~full_o;
  // Completions with nothing outstanding are stale and must not move done_id.
  assign w_done     = inc_done_i & busy_o;
  assign done_upd_o = w_done;
  assign w_next_inc = id_increment(32'(r_next_id), IdCounterWidth);
  assign w_done_inc = id_increment(32'(r_done_id), IdCounterWidth);
  assign next_id_o  = r_next_id;
  assign done_id_o  = r_done_id;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_next_id     <= IdCounterWidth'(1);
      r_done_id     <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_inc) begin
        r_next_id <= w_next_inc[IdCounterWidth-1:0];
      end
      if (w_done) begin
        r_done_id <= w_done_inc[IdCounterWidth-1:0];
      end
      if (w_inc && !w_done) begin
        r_outstanding <= r_outstanding + OutW'(1);
      end else if (!w_inc && w_done) begin
        r_outstanding <= r_outstanding - OutW'(1);
      end
    end
  end

endmodule

// File: rtl/idma_stream_dispatch.sv
// rtl/idma_stream_dispatch.sv - routes front-end requests to per-stream ports, tracks IDs
// Optional completion interrupt port irq_o enabled by IDMA_STREAM_DISPATCH_IRQ_EN.
module idma_stream_dispatch
  import idma_pkg::*;
#(
  parameter int unsigned NumStreams     = 1,
  parameter int unsigned IdCounterWidth = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1,
  parameter type         dma_req_t      = logic,
  parameter type         cnt_width_t    = logic [IdCounterWidth-1:0],
  parameter type         stream_t       = logic [StreamWidth-1:0]
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  dma_req_t              req_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  stream_t               stream_idx_i,
  output cnt_width_t            next_id_o,
  output dma_req_t              req_o       [NumStreams],
  output logic [NumStreams-1:0] req_valid_o,
  input  logic [NumStreams-1:0] req_ready_i,
  input  logic [NumStreams-1:0] cmpl_i,
  output cnt_width_t            done_id_o   [NumStreams],
  output logic [NumStreams-1:0] busy_o
`ifdef IDMA_STREAM_DISPATCH_IRQ_EN
  ,
  output logic [NumStreams-1:0] irq_o
`endif
);

  logic [NumStreams-1:0] w_full;
  logic [NumStreams-1:0] w_slot_free;
  logic [NumStreams-1:0] w_accept;
  logic [NumStreams-1:0] w_done_upd;
  cnt_width_t            w_next_id [NumStreams];
  dma_req_t              r_req     [NumStreams];
  logic                  r_valid   [NumStreams];
  logic                  w_sel_ready;
  cnt_width_t            w_sel_id;

  // Out-of-range indices select nothing: ready stays high so the request drains.
  always_comb begin
    w_sel_ready = 1'b1;
    w_sel_id    = '0;
    for (int s = 0; s < int'(NumStreams); s++) begin
      if (int'(stream_idx_i) == s) begin
        w_sel_ready = w_slot_free[s] & ~w_full[s];
        w_sel_id    = w_next_id[s];
      end
    end
  end

  assign req_ready_o = w_sel_ready;
  assign next_id_o   = w_sel_id;

  for (genvar s = 0; s < int'(NumStreams); s++) begin : g_stream
    assign w_slot_free[s] = ~r_valid[s] | req_ready_i[s];
    assign w_accept[s]    = req_valid_i & w_slot_free[s] & ~w_full[s] &
                            (int'(stream_idx_i) == s);
    assign req_o[s]       = r_req[s];
    assign req_valid_o[s] = r_valid[s];

    idma_stream_id_counter #(
      .IdCounterWidth (IdCounterWidth),
      .MaxOutstanding (MaxOutstanding)
    ) i_id_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_next_i (w_accept[s]),
      .inc_done_i (cmpl_i[s]),
      .next_id_o  (w_next_id[s]),
      .done_id_o  (done_id_o[s]),
      .full_o     (w_full[s]),
      .busy_o     (busy_o[s]),
      .done_upd_o (w_done_upd[s])
    );

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_req[s]   <= '0;
        r_valid[s] <= 1'b0;
      end else if (w_accept[s]) begin
        r_req[s]   <= req_i;
        r_valid[s] <= 1'b1;
      end else if (req_ready_i[s]) begin
        r_valid[s] <= 1'b0;
      end
    end

`ifdef IDMA_STREAM_DISPATCH_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_irq <= 1'b0;
      end else begin
        r_irq <= w_done_upd[s];
      end
    end

    assign irq_o[s] = r_irq;
`endif
  end

`ifndef IDMA_STREAM_DISPATCH_IRQ_EN
  logic w_unused_done_upd;
  assign w_unused_done_upd = ^w_done_upd;
`endif

endmodule

// File: tb/tb_idma_stream_dispatch.sv
// tb/tb_idma_stream_dispatch.sv - scoreboard bench for idma_stream_dispatch, 3 streams, 2-bit IDs
module tb_idma_stream_dispatch;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] req_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  stream_idx_i;
  logic [1:0]  next_id_o;
  logic [31:0] req_o [3];
  logic [2:0]  req_valid_o;
  logic [2:0]  req_ready_i;
  logic [2:0]  cmpl_i;
  logic [1:0]  done_id_o [3];
  logic [2:0]  busy_o;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [3][$];
  logic [1:0]  exp_ids [4] = '{2'd1, 2'd2, 2'd3, 2'd1};

  always #5 clk = ~clk;

  idma_stream_dispatch #(
    .NumStreams     (3),
    .IdCounterWidth (2),
    .MaxOutstanding (2),
    .dma_req_t      (logic [31:0])
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .stream_idx_i (stream_idx_i),
    .next_id_o    (next_id_o),
    .req_o        (req_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .cmpl_i       (cmpl_i),
    .done_id_o    (done_id_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every handoff on a stream must match the oldest request accepted for it.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int s = 0; s < 3; s++) begin
        if (req_valid_o[s] && req_ready_i[s]) begin
          if (exp_q[s].size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL sb_unexpected stream=%0d observed=%0h expected=none", s, req_o[s]);
          end else begin
            chk("sb_data", req_o[s], exp_q[s].pop_front());
          end
        end
      end
    end
  end

  task automatic send(input int s, input logic [31:0] d, input logic [1:0] id);
    int waited;
    waited       = 0;
    req_valid_i  = 1'b1;
    stream_idx_i = 2'(s);
    req_i        = d;
    @(negedge clk);
    while (!req_ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("send_ready", 32'(req_ready_o), 32'd1);
    chk("send_next_id", 32'(next_id_o), 32'(id));
    exp_q[s].push_back(d);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("lat_valid", 32'(req_valid_o[s]), 32'd1);
    chk("lat_data", req_o[s], d);
  endtask

  task automatic cmpl(input int s);
    cmpl_i[s] = 1'b1;
    @(posedge clk); #1;
    cmpl_i[s] = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_i        = '0;
    req_valid_i  = 1'b0;
    stream_idx_i = '0;
    req_ready_i  = 3'b111;
    cmpl_i       = '0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    chk("rst_valid", 32'(req_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_next_id", 32'(next_id_o), 32'd1);
    chk("rst_req0", req_o[0], 32'd0);
    for (int s = 0; s < 3; s++) chk("rst_done_id", 32'(done_id_o[s]), 32'd0);

    // Stream 0: IDs wrap 3 -> 1 skipping 0; done_id follows.
    for (int i = 0; i < 4; i++) begin
      send(0, 32'hA000_0000 + 32'(i), exp_ids[i]);
      chk("t1_busy", 32'(busy_o[0]), 32'd1);
      cmpl(0);
      chk("t1_done_id", 32'(done_id_o[0]), 32'(exp_ids[i]));
      chk("t1_idle", 32'(busy_o[0]), 32'd0);
    end
    chk("t1_next_id", 32'(next_id_o), 32'd2);

    // Stream 1: third request stalls at MaxOutstanding until a completion.
    send(1, 32'hB000_0001, 2'd1);
    send(1, 32'hB000_0002, 2'd2);
    req_valid_i  = 1'b1;
    stream_idx_i = 2'd1;
    req_i        = 32'hB000_0003;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_ready", 32'(req_ready_o), 32'd0);
      chk("t2_stall_next_id", 32'(next_id_o), 32'd3);
    end
    @(posedge clk); #1;
    cmpl_i[1] = 1'b1;
    @(posedge clk); #1;
    cmpl_i[1] = 1'b0;
    chk("t2_done_id", 32'(done_id_o[1]), 32'd1);
    @(negedge clk);
    chk("t2_ready", 32'(req_ready_o), 32'd1);
    chk("t2_next_id", 32'(next_id_o), 32'd3);
    exp_q[1].push_back(32'hB000_0003);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("t2_lat_valid", 32'(req_valid_o[1]), 32'd1);
    chk("t2_lat_data", req_o[1], 32'hB000_0003);
    cmpl(1);
    cmpl(1);
    chk("t2_done_end", 32'(done_id_o[1]), 32'd3);
    chk("t2_idle", 32'(busy_o[1]), 32'd0);

    // Stream 0 back-pressured: buffer holds, stream 1 keeps flowing.
    req_ready_i[0] = 1'b0;
    send(0, 32'hC000_0001, 2'd2);
    req_valid_i  = 1'b1;
    stream_idx_i = 2'd0;
    req_i        = 32'hC000_0002;
    repeat (5) begin
      @(negedge clk);
      chk("t3_ready", 32'(req_ready_o), 32'd0);
      chk("t3_hold_valid", 32'(req_valid_o[0]), 32'd1);
      chk("t3_hold_data", req_o[0], 32'hC000_0001);
    end
    @(posedge clk); #1;
    send(1, 32'hD000_0001, 2'd1);
    chk("t3_still_held", req_o[0], 32'hC000_0001);
    req_ready_i[0] = 1'b1;
    send(0, 32'hC000_0002, 2'd3);
    cmpl(0);
    cmpl(0);
    cmpl(1);
    chk("t3_all_idle", 32'(busy_o), 32'd0);

    // Stream 2: stale completion ignored; accept+completion in one cycle.
    cmpl(2);
    chk("t4_stale_done", 32'(done_id_o[2]), 32'd0);
    chk("t4_stale_busy", 32'(busy_o[2]), 32'd0);
    send(2, 32'hE000_0001, 2'd1);
    req_valid_i  = 1'b1;
    stream_idx_i = 2'd2;
    req_i        = 32'hE000_0002;
    cmpl_i[2]    = 1'b1;
    @(negedge clk);
    chk("t4_ready", 32'(req_ready_o), 32'd1);
    chk("t4_next_id", 32'(next_id_o), 32'd2);
    exp_q[2].push_back(32'hE000_0002);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    cmpl_i[2]   = 1'b0;
    chk("t4_busy", 32'(busy_o[2]), 32'd1);
    chk("t4_done_id", 32'(done_id_o[2]), 32'd1);
    chk("t4_lat_valid", 32'(req_valid_o[2]), 32'd1);
    chk("t4_lat_data", req_o[2], 32'hE000_0002);
    chk("t4_next_id_after", 32'(next_id_o), 32'd3);
    cmpl(2);
    chk("t4_done_end", 32'(done_id_o[2]), 32'd2);
    chk("t4_idle", 32'(busy_o[2]), 32'd0);

    // Out-of-range stream index: accepted and dropped.
    stream_idx_i = 2'd3;
    req_valid_i  = 1'b1;
    req_i        = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready_o), 32'd1);
    chk("t5_next_id", 32'(next_id_o), 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("t5_no_valid", 32'(req_valid_o), 32'd0);
    chk("t5_no_busy", 32'(busy_o), 32'd0);
    stream_idx_i = 2'd2;
    #1;
    chk("t5_id_unchanged", 32'(next_id_o), 32'd3);

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) chk("sb_drain", 32'(exp_q[s].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
